// File: rtl/operacional_pkg.sv
// ----------------------------------------------------------------------------
// operacional_pkg
// Shared types and constants for the electronic lock.
//   senhaPac_t    : 20 BCD key digits, [0] is the most recent key, unused = F
//   bcdPac_t      : 6 display digits, [0] = BCD0 (rightmost)
//   setupPac_t    : active configuration (buzzer, relock time, passwords)
//   SETUP_DEFAULT : configuration after reset (also used by setup's reset)
//   SENHA_VAZIA / SENHA_CANCELA : entries that are never matched or counted
// ----------------------------------------------------------------------------
package operacional_pkg;

    localparam int N_DIGITOS = 20;
    localparam int N_BCD     = 6;

    typedef logic [N_DIGITOS-1:0][3:0] senhaPac_t;
    typedef logic [N_BCD-1:0][3:0]     bcdPac_t;

    typedef struct packed {
        logic       bip_status;
        logic [5:0] bip_time;
        logic [5:0] tranca_aut_time;
        senhaPac_t  senha_master;
        senhaPac_t  senha_1;
        senhaPac_t  senha_2;
        senhaPac_t  senha_3;
        senhaPac_t  senha_4;
    } setupPac_t;

    localparam senhaPac_t SENHA_VAZIA   = {N_DIGITOS{4'hF}};
    localparam senhaPac_t SENHA_CANCELA = {N_DIGITOS{4'hB}};

    localparam senhaPac_t SENHA_MASTER_DEFAULT =
        {{(N_DIGITOS-4){4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};

    localparam setupPac_t SETUP_DEFAULT = '{
        bip_status:      1'b1,
        bip_time:        6'd5,
        tranca_aut_time: 6'd5,
        senha_master:    SENHA_MASTER_DEFAULT,
        senha_1:         SENHA_VAZIA,
        senha_2:         SENHA_VAZIA,
        senha_3:         SENHA_VAZIA,
        senha_4:         SENHA_VAZIA
    };

    localparam bcdPac_t BCD_APAGADO = {N_BCD{4'hF}};

    // A slot holding all-F is an unprogrammed slot and never matches.
    function automatic logic senha_confere(input senhaPac_t entrada,
                                           input senhaPac_t slot);
        return (slot != SENHA_VAZIA) && (entrada == slot);
    endfunction

    function automatic logic entrada_ignorada(input senhaPac_t entrada);
        return (entrada == SENHA_VAZIA) || (entrada == SENHA_CANCELA);
    endfunction

    // Two BCD digits {tens, units} of a value 0..99.
    function automatic logic [7:0] bcd_dois_digitos(input logic [6:0] valor);
        logic [3:0] dezenas;
        logic [3:0] unidades;
        dezenas  = 4'(valor / 7'd10);
        unidades = 4'(valor % 7'd10);
        return {dezenas, unidades};
    endfunction

endpackage

// File: rtl/operacional_tick_seg.sv
// ----------------------------------------------------------------------------
// operacional_tick_seg
// Seconds prescaler: counts 0..CLK_FREQ_HZ-1 and flags the last count.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   clr  : synchronous clear, restarts a full second
//   tick : high during the last cycle of each second (1 cycle wide)
// ----------------------------------------------------------------------------
module operacional_tick_seg #(
    parameter int CLK_FREQ_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [W-1:0] ULTIMO = W'(CLK_FREQ_HZ - 1);

    logic [W-1:0] cnt_reg;

    // Decoded straight from the counter: tick must not depend on clr, because
    // the parent derives clr from its next-state logic, which uses tick.
    assign tick = (cnt_reg == ULTIMO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || (cnt_reg == ULTIMO)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/operacional.sv
// ----------------------------------------------------------------------------
// operacional
// Normal-mode controller of the electronic lock. Matches keypad entries
// against the active configuration, drives the bolt, times auto-relock and
// the door-open buzzer, locks the keypad out after repeated wrong entries and
// hands over to setup on the master password.
//   clk, rst        : clock, asynchronous active-low reset
//   digitos_value   : keypad digits, qualified by digitos_valid (1 cycle)
//   sensor_porta    : 1 = door closed
//   botao_interno   : inside open button (level)
//   data_setup_new  : new configuration, taken on data_setup_ok in SETUP
//   setup_on        : 1-cycle pulse starting setup
//   tranca          : 1 = bolt engaged
//   bip             : buzzer
//   display_en      : this block drives the display (lockout countdown)
//   bcd_pac         : display digits BCD0..BCD5
// All outputs are registered from next-state values, so they change on the
// same edge as the state register (Moore timing, no combinational paths).
// ----------------------------------------------------------------------------
module operacional
    import operacional_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 1000,
    parameter int MAX_TENTATIVAS = 5,
    parameter int BLOQUEIO_S     = 30
) (
    input  logic      clk,
    input  logic      rst,
    input  senhaPac_t digitos_value,
    input  logic      digitos_valid,
    input  logic      sensor_porta,
    input  logic      botao_interno,
    input  setupPac_t data_setup_new,
    input  logic      data_setup_ok,
    output logic      setup_on,
    output logic      tranca,
    output logic      bip,
    output logic      display_en,
    output bcdPac_t   bcd_pac
);

    typedef enum logic [2:0] {
        TRAVADO,
        DESTRAVADO,
        PORTA_ABERTA,
        BLOQUEIO,
        SETUP
    } estado_t;

    localparam logic [3:0] FALHAS_LIMITE = 4'(MAX_TENTATIVAS - 1);
    localparam logic [6:0] RESTANTE_INI  = 7'(BLOQUEIO_S);
    localparam logic [5:0] SEGUNDOS_MAX  = 6'd63;

    estado_t   estado_reg,   estado_next;
    setupPac_t cfg_reg,      cfg_next;
    logic [3:0] falhas_reg,  falhas_next;
    logic [5:0] segundos_reg, segundos_next;
    logic [6:0] restante_reg, restante_next;

    logic      setup_on_reg,   setup_on_next;
    logic      tranca_reg,     tranca_next;
    logic      bip_reg,        bip_next;
    logic      display_en_reg, display_en_next;
    bcdPac_t   bcd_reg,        bcd_next;

    logic      tick;
    logic      transicao;
    logic      entrada_ok;
    logic      confere_master;
    logic      fim_relock;
    logic [3:0] confere_slot;
    senhaPac_t  senha_usuario [4];

    // ------------------------------------------------------------------
    // Password comparison, one comparator per user slot
    // ------------------------------------------------------------------
    assign senha_usuario[0] = cfg_reg.senha_1;
    assign senha_usuario[1] = cfg_reg.senha_2;
    assign senha_usuario[2] = cfg_reg.senha_3;
    assign senha_usuario[3] = cfg_reg.senha_4;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign confere_slot[gi] = senha_confere(digitos_value, senha_usuario[gi]);
    end

    assign confere_master = senha_confere(digitos_value, cfg_reg.senha_master);
    assign entrada_ok     = digitos_valid && !entrada_ignorada(digitos_value);

    // Relock fires on the tick that would make the count equal the
    // configured time, so the bolt stays open exactly N full seconds.
    // The first term covers a configured time of zero.
    assign fim_relock = (segundos_reg == cfg_reg.tranca_aut_time) ||
                        (tick && ((segundos_reg + 6'd1) == cfg_reg.tranca_aut_time));

    // Any state change restarts the prescaler so each state starts with a
    // full second.
    assign transicao = (estado_next != estado_reg);

    operacional_tick_seg #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick_seg (
        .clk  (clk),
        .rst  (rst),
        .clr  (transicao),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        estado_next = estado_reg;
        cfg_next    = cfg_reg;
        falhas_next = falhas_reg;

        case (estado_reg)
            TRAVADO: begin
                // The button wins over a digit strobe in the same cycle;
                // the strobe is dropped and not counted.
                if (botao_interno) begin
                    estado_next = DESTRAVADO;
                end else if (entrada_ok) begin
                    if (|confere_slot) begin
                        estado_next = DESTRAVADO;
                        falhas_next = '0;
                    end else if (confere_master) begin
                        estado_next = SETUP;
                        falhas_next = '0;
                    end else if (falhas_reg >= FALHAS_LIMITE) begin
                        estado_next = BLOQUEIO;
                        falhas_next = '0;
                    end else begin
                        falhas_next = falhas_reg + 4'd1;
                    end
                end
            end
            DESTRAVADO: begin
                if (!sensor_porta) begin
                    estado_next = PORTA_ABERTA;
                end else if (fim_relock) begin
                    estado_next = TRAVADO;
                end
            end
            PORTA_ABERTA: begin
                if (sensor_porta) begin
                    estado_next = DESTRAVADO;
                end
            end
            BLOQUEIO: begin
                if (tick && (restante_reg <= 7'd1)) begin
                    estado_next = TRAVADO;
                end
            end
            SETUP: begin
                if (data_setup_ok) begin
                    cfg_next    = data_setup_new;
                    estado_next = TRAVADO;
                end
            end
            default: begin
                estado_next = TRAVADO;
            end
        endcase

        // Seconds count saturates so a door left open keeps the buzzer on.
        // The lockout countdown is reloaded on every transition; it only
        // matters after entering BLOQUEIO.
        segundos_next = segundos_reg;
        restante_next = restante_reg;
        if (transicao) begin
            segundos_next = '0;
            restante_next = RESTANTE_INI;
        end else if (tick) begin
            if (segundos_reg != SEGUNDOS_MAX) begin
                segundos_next = segundos_reg + 6'd1;
            end
            if (restante_reg != 7'd0) begin
                restante_next = restante_reg - 7'd1;
            end
        end

        // Output decode from the next state
        tranca_next     = !((estado_next == DESTRAVADO) || (estado_next == PORTA_ABERTA));
        bip_next        = (estado_next == PORTA_ABERTA) && cfg_next.bip_status &&
                          (segundos_next >= cfg_next.bip_time);
        display_en_next = (estado_next == BLOQUEIO);
        setup_on_next   = (estado_next == SETUP) && (estado_reg != SETUP);
        if (estado_next == BLOQUEIO) begin
            bcd_next = {4'hE, 4'hF, 4'hF, 4'hF, bcd_dois_digitos(restante_next)};
        end else begin
            bcd_next = BCD_APAGADO;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_reg     <= TRAVADO;
            cfg_reg        <= SETUP_DEFAULT;
            falhas_reg     <= '0;
            segundos_reg   <= '0;
            restante_reg   <= '0;
            setup_on_reg   <= 1'b0;
            tranca_reg     <= 1'b1;
            bip_reg        <= 1'b0;
            display_en_reg <= 1'b0;
            bcd_reg        <= BCD_APAGADO;
        end else begin
            estado_reg     <= estado_next;
            cfg_reg        <= cfg_next;
            falhas_reg     <= falhas_next;
            segundos_reg   <= segundos_next;
            restante_reg   <= restante_next;
            setup_on_reg   <= setup_on_next;
            tranca_reg     <= tranca_next;
            bip_reg        <= bip_next;
            display_en_reg <= display_en_next;
            bcd_reg        <= bcd_next;
        end
    end

    assign setup_on   = setup_on_reg;
    assign tranca     = tranca_reg;
    assign bip        = bip_reg;
    assign display_en = display_en_reg;
    assign bcd_pac    = bcd_reg;

endmodule

// File: tb/tb_operacional.sv
// ----------------------------------------------------------------------------
// tb_operacional
// Directed sequence with randomized passwords, slots and timings. Expected
// behaviour comes from a small model of the lock's rules: the user password,
// master password, relock/buzzer times and the consecutive-failure count.
// ----------------------------------------------------------------------------
module tb_operacional;
    import operacional_pkg::*;

    localparam int CLK_HZ = 10;
    localparam int MAX_T  = 5;
    localparam int BLOQ_S = 30;

    localparam senhaPac_t TB_VAZIA   = {20{4'hF}};
    localparam senhaPac_t TB_CANCELA = {20{4'hB}};
    localparam senhaPac_t TB_MASTER  = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};
    localparam senhaPac_t TB_55555   = {{15{4'hF}}, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};

    logic      clk = 1'b0;
    logic      rst;
    senhaPac_t digitos_value;
    logic      digitos_valid;
    logic      sensor_porta;
    logic      botao_interno;
    setupPac_t data_setup_new;
    logic      data_setup_ok;
    logic      setup_on;
    logic      tranca;
    logic      bip;
    logic      display_en;
    bcdPac_t   bcd_pac;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the lock's configuration and failure count
    senhaPac_t m_senha1;
    senhaPac_t m_master;
    int        m_aut;
    int        m_bip_time;
    logic      m_bip_status;
    int        m_falhas;

    operacional #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .MAX_TENTATIVAS (MAX_T),
        .BLOQUEIO_S     (BLOQ_S)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .digitos_value  (digitos_value),
        .digitos_valid  (digitos_valid),
        .sensor_porta   (sensor_porta),
        .botao_interno  (botao_interno),
        .data_setup_new (data_setup_new),
        .data_setup_ok  (data_setup_ok),
        .setup_on       (setup_on),
        .tranca         (tranca),
        .bip            (bip),
        .display_en     (display_en),
        .bcd_pac        (bcd_pac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_senha1     = TB_VAZIA;
        m_master     = TB_MASTER;
        m_aut        = 5;
        m_bip_time   = 5;
        m_bip_status = 1'b1;
        m_falhas     = 0;
    endtask

    function automatic senhaPac_t rand_pw();
        senhaPac_t p;
        p = TB_VAZIA;
        for (int d = 0; d < 5; d++) p[d] = 4'($urandom_range(0, 9));
        return p;
    endfunction

    function automatic senhaPac_t rand_wrong();
        senhaPac_t p;
        p = rand_pw();
        while (p == m_senha1) p = rand_pw();
        return p;
    endfunction

    task automatic enter(input senhaPac_t p);
        digitos_value = p;
        digitos_valid = 1'b1;
        step(1);
        digitos_valid = 1'b0;
        digitos_value = TB_VAZIA;
        $display("[tx] t=%0t entry=%h tranca=%b display_en=%b", $time, p, tranca, display_en);
    endtask

    // Full lockout: display counts remaining seconds, all inputs ignored.
    task automatic lock_run();
        int rem;
        for (int j = 0; j < BLOQ_S * CLK_HZ; j++) begin
            rem = BLOQ_S - j / CLK_HZ;
            chk("lock_display_en", display_en, 1);
            chk("lock_tranca", tranca, 1);
            chk("lock_setup_on", setup_on, 0);
            chk("lock_bcd", bcd_pac, {8'hEF, 8'hFF, 4'(rem / 10), 4'(rem % 10)});
            digitos_valid = (j == 45) || (j == 120);
            digitos_value = (j == 45) ? m_senha1 : m_master;
            botao_interno = (j == 90);
            step(1);
        end
        digitos_valid = 1'b0;
        digitos_value = TB_VAZIA;
        botao_interno = 1'b0;
        chk("after_lock_display_en", display_en, 0);
        chk("after_lock_tranca", tranca, 1);
        chk("after_lock_bcd", bcd_pac, 32'hFFFFFF);
        $display("[tx] t=%0t lockout finished", $time);
    endtask

    task automatic wrong_entry(input senhaPac_t p);
        enter(p);
        m_falhas++;
        if (m_falhas == MAX_T) begin
            m_falhas = 0;
            lock_run();
        end else begin
            chk("wrong_tranca", tranca, 1);
            chk("wrong_display_en", display_en, 0);
        end
    endtask

    task automatic unlock(input senhaPac_t p);
        enter(p);
        m_falhas = 0;
        chk("unlock_tranca", tranca, 0);
        chk("unlock_display_en", display_en, 0);
    endtask

    task automatic wait_relock();
        int n;
        n = 0;
        while (tranca !== 1'b1 && n < 2000) begin
            step(1);
            n++;
        end
        chk("relock_cycles", n, m_aut * CLK_HZ);
        $display("[tx] t=%0t relock after %0d cycles", $time, n);
    endtask

    task automatic door_run(input int len);
        int sec;
        logic exp_bip;
        sensor_porta = 1'b0;
        step(1);
        for (int i = 0; i < len; i++) begin
            sec = i / CLK_HZ;
            if (sec > 63) sec = 63;
            exp_bip = m_bip_status && (sec >= m_bip_time);
            chk("open_bip", bip, exp_bip);
            chk("open_tranca", tranca, 0);
            step(1);
        end
        sensor_porta = 1'b1;
        step(1);
        chk("closed_bip", bip, 0);
        chk("closed_tranca", tranca, 0);
        $display("[tx] t=%0t door closed after %0d cycles open", $time, len);
        wait_relock();
    endtask

    task automatic unlock_and_door(input int len);
        unlock(m_senha1);
        step($urandom_range(0, m_aut * CLK_HZ - 2));
        door_run(len);
    endtask

    // Enter setup with the master password and program the user password
    // into a random slot.
    task automatic do_setup(input senhaPac_t pw, input logic bs, input int bt, input int aut);
        int slot;
        enter(m_master);
        chk("setup_on_pulse", setup_on, 1);
        chk("setup_tranca", tranca, 1);
        chk("setup_display_en", display_en, 0);
        step(1);
        chk("setup_on_single", setup_on, 0);
        enter(m_master);
        chk("setup_master_ignored", setup_on, 0);
        enter(m_senha1);
        chk("setup_digits_ignored", tranca, 1);
        slot = $urandom_range(0, 3);
        data_setup_new = '{
            bip_status:      bs,
            bip_time:        6'(bt),
            tranca_aut_time: 6'(aut),
            senha_master:    m_master,
            senha_1:         (slot == 0) ? pw : TB_VAZIA,
            senha_2:         (slot == 1) ? pw : TB_VAZIA,
            senha_3:         (slot == 2) ? pw : TB_VAZIA,
            senha_4:         (slot == 3) ? pw : TB_VAZIA
        };
        data_setup_ok = 1'b1;
        step(1);
        data_setup_ok = 1'b0;
        chk("setup_exit_tranca", tranca, 1);
        chk("setup_exit_setup_on", setup_on, 0);
        m_senha1     = pw;
        m_bip_status = bs;
        m_bip_time   = bt;
        m_aut        = aut;
        m_falhas     = 0;
        $display("[tx] t=%0t setup saved slot=%0d bs=%b bt=%0d aut=%0d", $time, slot, bs, bt, aut);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tranca"}, tranca, 1);
        chk({tag, "_bip"}, bip, 0);
        chk({tag, "_setup_on"}, setup_on, 0);
        chk({tag, "_display_en"}, display_en, 0);
        chk({tag, "_bcd"}, bcd_pac, 32'hFFFFFF);
    endtask

    initial begin
        senhaPac_t other;
        rst            = 1'b0;
        digitos_value  = TB_VAZIA;
        digitos_valid  = 1'b0;
        sensor_porta   = 1'b1;
        botao_interno  = 1'b0;
        data_setup_new = '0;
        data_setup_ok  = 1'b0;
        model_reset();

        // Reset state
        step(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        step(2);

        // Empty and cancel entries are never counted
        for (int k = 0; k < 12; k++) begin
            enter((k % 2 == 0) ? TB_VAZIA : TB_CANCELA);
        end
        chk("empty_cancel_tranca", tranca, 1);
        chk("empty_cancel_display_en", display_en, 0);
        for (int k = 0; k < MAX_T - 1; k++) wrong_entry(rand_wrong());

        // Master password enters setup; program 55555
        do_setup(TB_55555, 1'b1, 5, 5);
        unlock(m_senha1);
        wait_relock();

        // Door left open long enough for the seconds count to saturate
        unlock_and_door(700);

        // data_setup_ok outside SETUP is ignored
        other = rand_wrong();
        data_setup_new = '{
            bip_status: 1'b0, bip_time: 6'd1, tranca_aut_time: 6'd2,
            senha_master: TB_VAZIA, senha_1: other, senha_2: other,
            senha_3: other, senha_4: other
        };
        data_setup_ok = 1'b1;
        step(1);
        data_setup_ok = 1'b0;
        wrong_entry(other);
        unlock(m_senha1);
        wait_relock();

        // Random configuration with the buzzer disabled
        do_setup(rand_pw(), 1'b0, $urandom_range(0, 9), $urandom_range(1, 6));
        unlock_and_door($urandom_range(60, 200));

        // Random configuration with the buzzer enabled
        do_setup(rand_pw(), 1'b1, $urandom_range(0, 9), $urandom_range(1, 6));
        unlock_and_door($urandom_range(60, 200));
        unlock(m_senha1);
        wait_relock();

        // Partial failures cleared by a successful match
        repeat ($urandom_range(1, MAX_T - 1)) begin
            wrong_entry(rand_wrong());
            enter(TB_CANCELA);
        end
        unlock(m_senha1);
        wait_relock();

        // Lockout after MAX_T consecutive wrong entries
        repeat (MAX_T) begin
            wrong_entry(rand_wrong());
            enter(TB_VAZIA);
        end

        // Counter restarts from zero after lockout
        repeat (MAX_T - 1) wrong_entry(rand_wrong());
        unlock(m_senha1);
        wait_relock();

        // Button and wrong entry in the same cycle: unlock, no failure counted
        repeat (3) wrong_entry(rand_wrong());
        botao_interno = 1'b1;
        digitos_value = rand_wrong();
        digitos_valid = 1'b1;
        step(1);
        botao_interno = 1'b0;
        digitos_valid = 1'b0;
        digitos_value = TB_VAZIA;
        chk("button_tranca", tranca, 0);
        chk("button_display_en", display_en, 0);
        wait_relock();
        repeat (MAX_T - 3) wrong_entry(rand_wrong());

        // Reset while the door is open and the buzzer is sounding
        unlock(m_senha1);
        sensor_porta = 1'b0;
        step(1);
        step(CLK_HZ * (m_bip_time + 1));
        chk("pre_reset_bip", bip, m_bip_status);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_open");
        sensor_porta = 1'b1;
        step(2);
        rst = 1'b1;
        other = m_senha1;
        model_reset();
        step(1);
        wrong_entry(other);

        // Reset while in SETUP; defaults restored, master works again
        enter(m_master);
        chk("setup_before_reset", setup_on, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_setup");
        step(2);
        rst = 1'b1;
        model_reset();
        step(1);
        do_setup(rand_pw(), 1'b1, $urandom_range(0, 9), $urandom_range(1, 6));
        unlock(m_senha1);
        wait_relock();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
